// File: rtl/lottery_pkg.sv
// Shared types and LFSR helpers for the multi-winner lottery draw.
// The LFSRs shift right: the feedback bit enters at the MSB and taps sit at bit (W - exponent).
package lottery_pkg;

  typedef enum logic [1:0] {OPEN, DRAW, PRESENT, DONE} state_t;

  // x^16+x^14+x^13+x^11+1 -> bits 0,2,3,5 ; x^32+x^22+x^2+x^1+1 -> bits 0,10,30,31
  localparam logic [15:0] LFSR_TAPS_16 = 16'h002D;
  localparam logic [31:0] LFSR_TAPS_32 = 32'hC000_0401;

  function automatic logic [31:0] lfsr_next(input int unsigned width, input logic [31:0] value);
    logic [31:0] taps;
    logic        fb;
    logic [31:0] res;
    taps = (width == 32) ? LFSR_TAPS_32 : {16'h0000, LFSR_TAPS_16};
    fb   = ^(value & taps);
    if (width == 32) res = {fb, value[31:1]};
    else             res = {16'h0000, fb, value[15:1]};
    return res;
  endfunction

endpackage

// File: rtl/lottery_lfsr.sv
// Free-running Fibonacci LFSR with a seed-load port; a zero seed becomes 1 so it can never lock up.
module lottery_lfsr
  import lottery_pkg::*;
#(
  parameter int                LFSR_W    = 16,
  parameter logic [LFSR_W-1:0] SEED_INIT = 'hACE1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  input  logic              seed_load,
  output logic [LFSR_W-1:0] q
);

  logic [LFSR_W-1:0] q_reg, q_next;

  always_comb begin
    q_next = LFSR_W'(lfsr_next(LFSR_W, 32'(q_reg)));
    if (seed_load) q_next = (seed == '0) ? LFSR_W'(1) : seed;
  end

  always_ff @(posedge clk) begin
    if (reset) q_reg <= SEED_INIT;
    else       q_reg <= q_next;
  end

  assign q = q_reg;

endmodule

// File: rtl/lottery_draw.sv
// Ticket registration followed by a seeded draw of NUM_WINNERS distinct eligible tickets,
// each presented over a valid/ready handshake.
module lottery_draw
  import lottery_pkg::*;
#(
  parameter int                MAX_ENTRIES = 32,
  parameter int                ID_W        = $clog2(MAX_ENTRIES),
  parameter int                NUM_WINNERS = 3,
  parameter int                LFSR_W      = 16,
  parameter logic [LFSR_W-1:0] SEED_INIT   = 'hACE1,
  parameter bit                AUTO_DRAW   = 1'b1
)(
  input  logic              clk,
  input  logic              reset,
  input  logic [LFSR_W-1:0] seed,
  input  logic              seed_load,
  input  logic              write,
  input  logic              luckybit,
  input  logic              stop,
  output logic [ID_W:0]     id,
  output logic              full,
  output logic              busy,
  output logic              winner_valid,
  input  logic              winner_ready,
  output logic [ID_W-1:0]   winner_id,
  output logic [ID_W:0]     winner_ord,
  output logic              draw_done,
  output logic              short_draw
);

  localparam logic [ID_W:0]   CAPACITY = (ID_W+1)'(MAX_ENTRIES);
  localparam logic [ID_W:0]   LAST_ORD = (ID_W+1)'(NUM_WINNERS - 1);
  localparam logic [ID_W-1:0] LAST_TRY = ID_W'(MAX_ENTRIES - 1);

  logic [LFSR_W-1:0] lfsr_q;
  logic              unused_lfsr_bits;

  state_t                 state_reg, state_next;
  logic [ID_W:0]          id_reg, id_next, ord_reg, ord_next;
  logic [MAX_ENTRIES-1:0] lucky_reg, lucky_next, won_reg, won_next, elig;
  logic [ID_W-1:0]        probe_reg, probe_next, tries_reg, tries_next;
  logic [ID_W-1:0]        winner_reg, winner_next;
  logic                   short_reg, short_next;

  lottery_lfsr #(.LFSR_W(LFSR_W), .SEED_INIT(SEED_INIT)) u_lfsr (
    .clk       (clk),
    .reset     (reset),
    .seed      (seed),
    .seed_load (seed_load),
    .q         (lfsr_q)
  );

  assign unused_lfsr_bits = ^lfsr_q[LFSR_W-1:ID_W];

  // A ticket can win only if registered, lucky and not already drawn.
  for (genvar gi = 0; gi < MAX_ENTRIES; gi++) begin : g_elig
    assign elig[gi] = lucky_reg[gi] && !won_reg[gi] && (id_reg > (ID_W+1)'(gi));
  end

  always_comb begin
    state_next  = state_reg;
    id_next     = id_reg;
    ord_next    = ord_reg;
    lucky_next  = lucky_reg;
    won_next    = won_reg;
    probe_next  = probe_reg;
    tries_next  = tries_reg;
    winner_next = winner_reg;
    short_next  = short_reg;
    unique case (state_reg)
      OPEN: begin
        if (write && id_reg != CAPACITY) begin
          lucky_next[id_reg[ID_W-1:0]] = luckybit;
          id_next = id_reg + 1'b1;
        end
        if (stop || (AUTO_DRAW && id_reg == CAPACITY)) begin
          state_next = DRAW;
          probe_next = lfsr_q[ID_W-1:0];
          tries_next = '0;
        end
      end
      DRAW: begin
        if (elig[probe_reg]) begin
          winner_next = probe_reg;
          state_next  = PRESENT;
        end else if (tries_reg == LAST_TRY) begin
          state_next = DONE;
          short_next = 1'b1;
        end else begin
          probe_next = probe_reg + 1'b1;
          tries_next = tries_reg + 1'b1;
        end
      end
      PRESENT: begin
        if (winner_ready) begin
          won_next[winner_reg] = 1'b1;
          ord_next = ord_reg + 1'b1;
          if (ord_reg == LAST_ORD) begin
            state_next = DONE;
          end else begin
            state_next = DRAW;
            probe_next = lfsr_q[ID_W-1:0];
            tries_next = '0;
          end
        end
      end
      DONE: ;
      default: state_next = OPEN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= OPEN;
      id_reg     <= '0;
      ord_reg    <= '0;
      lucky_reg  <= '0;
      won_reg    <= '0;
      probe_reg  <= '0;
      tries_reg  <= '0;
      winner_reg <= '0;
      short_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      id_reg     <= id_next;
      ord_reg    <= ord_next;
      lucky_reg  <= lucky_next;
      won_reg    <= won_next;
      probe_reg  <= probe_next;
      tries_reg  <= tries_next;
      winner_reg <= winner_next;
      short_reg  <= short_next;
    end
  end

  assign id           = id_reg;
  assign full         = (id_reg == CAPACITY);
  assign busy         = (state_reg == DRAW) || (state_reg == PRESENT);
  assign winner_valid = (state_reg == PRESENT);
  assign winner_id    = winner_reg;
  assign winner_ord   = ord_reg;
  assign draw_done    = (state_reg == DONE);
  assign short_draw   = short_reg;

endmodule

// File: doc/lottery_draw.md
Name: lottery_draw

Overview:
- Parametrised successor of the single-winner lottery.
- Registers up to MAX_ENTRIES tickets, each with an eligibility (lucky) bit.
- After stop, or after full when AUTO_DRAW=1, draws NUM_WINNERS distinct eligible entries using a seeded LFSR plus a bounded linear probe.
- Presents winners one at a time over a valid/ready handshake. Fully synchronous; sits between ticket-entry logic and the display/announce logic.

Parameters:
- MAX_ENTRIES, 32, ticket capacity; power of two, 4..256.
- ID_W, $clog2(MAX_ENTRIES), ticket index width.
- NUM_WINNERS, 3, winners to draw; 1..MAX_ENTRIES.
- LFSR_W, 16, LFSR width; 16 or 32 only; must be >= ID_W.
- SEED_INIT, 16'hACE1, LFSR value after reset; must be nonzero.
- AUTO_DRAW, 1, 1 = full starts the draw without stop.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- seed  in  LFSR_W  seed value, used when seed_load=1
- seed_load  in  1  load seed into LFSR this cycle
- write  in  1  single-cycle ticket write strobe
- luckybit  in  1  eligibility bit of the ticket being written
- stop  in  1  close registration and start the draw
- id  out  ID_W+1  number of tickets registered (next free index)
- full  out  1  id == MAX_ENTRIES
- busy  out  1  state is DRAW or PRESENT
- winner_valid  out  1  winner_id is valid
- winner_ready  in  1  consumer accepts the winner
- winner_id  out  ID_W  index of the winning ticket
- winner_ord  out  ID_W+1  0-based ordinal of the winner
- draw_done  out  1  draw finished; held until reset
- short_draw  out  1  fewer than NUM_WINNERS eligible entries existed; valid while draw_done=1

Behaviour:
- Reset (synchronous, active-high, wins over every other input):
  - state=OPEN; id=0; lucky and won vectors = 0; lfsr=SEED_INIT.
  - All outputs 0.
  - Reset mid-draw or mid-handshake aborts immediately; no winner is retained.
- LFSR:
  - Maximal-length Fibonacci. Taps: 16-bit x^16+x^14+x^13+x^11+1; 32-bit x^32+x^22+x^2+x^1+1.
  - Advances every cycle in every state.
  - seed_load has priority over advance; seed=0 loads 1 (zero-lock guard).
- OPEN:
  - write with id<MAX_ENTRIES: lucky[id]<=luckybit, id<=id+1.
  - write while full: ignored, no error.
  - stop, or (AUTO_DRAW && full): go to DRAW next edge.
  - write and stop in the same cycle: the write is accepted and the ticket is included in the draw.
- DRAW:
  - On entry: probe<=lfsr[ID_W-1:0], tries<=0.
  - Each cycle, hit = probe<id && lucky[probe] && !won[probe].
  - Hit: latch winner_id=probe, go to PRESENT.
  - Miss: probe<=probe+1 (wraps mod MAX_ENTRIES), tries++.
  - tries==MAX_ENTRIES-1 with a miss: go to DONE with short_draw=1.
  - Draw length is bounded at MAX_ENTRIES cycles.
- PRESENT:
  - winner_valid=1; winner_id and winner_ord held stable until winner_ready.
  - On handshake: won[winner_id]<=1, winner_ord++.
  - If winner_ord+1==NUM_WINNERS go to DONE, else go to DRAW with a new probe from the current lfsr.
  - Deassertion of winner_ready never drops valid.
- DONE:
  - draw_done=1; write and stop ignored.
  - Leaves DONE only on reset.
- stop asserted while in DRAW or PRESENT: ignored.
- Latency: stop to first winner_valid is 2 cycles when the first probe hits, plus 1 cycle per miss.
- id=0 at draw start: no probe can hit, so DONE with short_draw=1 after MAX_ENTRIES cycles.
- Widths: id and winner_ord are ID_W+1 bits so MAX_ENTRIES is representable. Probe arithmetic is ID_W bits with natural wrap.

Decomposition:
- Package lottery_pkg holds:
  - state enum {OPEN, DRAW, PRESENT, DONE};
  - the LFSR tap constants for widths 16 and 32;
  - function lfsr_next(width, value).
- One sub-module, lottery_lfsr: parameter LFSR_W and SEED_INIT; ports clk, reset, seed, seed_load, q.
- The FSM, ticket store and probe logic stay in lottery_draw.

Test Plan:
- MAX_ENTRIES=8, NUM_WINNERS=3. Write 8 tickets, all luckybit=1, winner_ready=1 -> full=1 after the 8th write; three distinct winner_id values with winner_ord 0,1,2; then draw_done=1, short_draw=0.
- Lucky pattern 8'b0000_0100 (only ticket 2 eligible), then stop -> one winner with winner_id=2; then draw_done=1, short_draw=1 within 8 cycles of the second DRAW entry.
- seed_load with seed=0 -> LFSR holds 1, never locks at 0. Two runs with the same seed and the same stimulus -> identical winner sequence.
- Hold winner_ready=0 for 5 cycles during PRESENT -> winner_valid=1 and winner_id unchanged throughout; one winner consumed when ready rises.
- write and stop in the same cycle at id=4 -> id=5 and ticket 4 is eligible for the draw. Writes after full, or in DONE -> id unchanged.
- Assert reset while in PRESENT -> next cycle all outputs 0, id=0, state OPEN; a fresh registration works normally.
